// File: rtl/game_state_bank.sv
// game_state_bank: breakout game state registers committed once per frame tick,
// with a vsync-latched display snapshot.
module game_state_bank #(
  parameter int NBRICK = 10,
  parameter int HPW = 2,
  parameter int CW = 10,
  parameter int LW = 2,
  parameter int VITE = 3,
  parameter int IX_NAV = 320,
  parameter int IY_NAV = 470,
  parameter int IX_PAL = 320,
  parameter int IY_PAL = 450,
  parameter logic [NBRICK*HPW-1:0] HP_INIT = 20'h56AFF,
  localparam int BCW = $clog2(NBRICK+1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic [CW-1:0]          i_xnav,
  input  logic [CW-1:0]          i_ynav,
  input  logic [CW-1:0]          i_xpal,
  input  logic [CW-1:0]          i_ypal,
  input  logic                   i_xdirpal,
  input  logic                   i_ydirpal,
  input  logic [NBRICK-1:0]      i_hit,
  input  logic                   i_lost,
  input  logic                   i_serve,
  input  logic                   vsync,
  output logic [CW-1:0]          o_xnav,
  output logic [CW-1:0]          o_ynav,
  output logic [CW-1:0]          o_xpal,
  output logic [CW-1:0]          o_ypal,
  output logic                   o_xdirpal,
  output logic                   o_ydirpal,
  output logic [NBRICK*HPW-1:0]  o_hp,
  output logic [NBRICK-1:0]      o_alive,
  output logic [BCW-1:0]         o_brick,
  output logic [LW-1:0]          o_life,
  output logic [1:0]             o_state,
  output logic [CW-1:0]          d_xnav,
  output logic [CW-1:0]          d_xpal,
  output logic [CW-1:0]          d_ypal,
  output logic [NBRICK*HPW-1:0]  d_hp
);
  typedef enum logic [1:0] {SERVE = 2'b00, PLAY = 2'b01, OVER = 2'b10, WIN = 2'b11} state_t;
  function automatic logic [NBRICK-1:0] alive_of(input logic [NBRICK*HPW-1:0] v);
    for (int i = 0; i < NBRICK; i++) alive_of[i] = v[i*HPW +: HPW] != '0;
  endfunction
  localparam logic [NBRICK-1:0] ALIVE_INIT = alive_of(HP_INIT);
  localparam logic [BCW-1:0] BRICK_INIT = BCW'($countones(ALIVE_INIT));
  state_t state, state_n;
  logic [CW-1:0] xnav_n, ynav_n, xpal_n, ypal_n;
  logic xdir_n, ydir_n;
  logic [NBRICK*HPW-1:0] hp_n, hp_hit;
  logic [NBRICK-1:0] alive_n, alive_hit;
  logic [BCW-1:0] brick_n, brick_hit;
  logic [LW-1:0] life_n;
  assign o_state = state;
  always_comb begin
    hp_hit = o_hp;
    for (int i = 0; i < NBRICK; i++)
      hp_hit[i*HPW +: HPW] = (i_hit[i] && o_hp[i*HPW +: HPW] != '0) ? o_hp[i*HPW +: HPW] - HPW'(1) : o_hp[i*HPW +: HPW];
    alive_hit = alive_of(hp_hit);
    brick_hit = BCW'($countones(alive_hit));
    state_n = state;
    xnav_n = o_xnav;
    ynav_n = o_ynav;
    xpal_n = o_xpal;
    ypal_n = o_ypal;
    xdir_n = o_xdirpal;
    ydir_n = o_ydirpal;
    hp_n = o_hp;
    alive_n = o_alive;
    brick_n = o_brick;
    life_n = o_life;
    if (tick)
      case (state)
        SERVE: begin
          xnav_n = i_xnav;
          ynav_n = i_ynav;
          xpal_n = i_xnav;
          ypal_n = CW'(IY_PAL);
          xdir_n = 1'b0;
          ydir_n = 1'b0;
          state_n = i_serve ? PLAY : SERVE;
        end
        PLAY: begin
          xnav_n = i_xnav;
          ynav_n = i_ynav;
          xpal_n = i_xpal;
          ypal_n = i_ypal;
          xdir_n = i_xdirpal;
          ydir_n = i_ydirpal;
          hp_n = hp_hit;
          alive_n = alive_hit;
          brick_n = brick_hit;
          // clearing the field wins over a lost ball on the same tick
          if (brick_hit == '0) state_n = WIN;
          else if (i_lost) begin
            life_n = o_life - LW'(1);
            if (o_life == LW'(1)) state_n = OVER;
            else begin
              state_n = SERVE;
              xpal_n = CW'(IX_PAL);
              ypal_n = CW'(IY_PAL);
              xdir_n = 1'b0;
              ydir_n = 1'b0;
            end
          end
        end
        default: ;
      endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= SERVE;
      o_xnav <= CW'(IX_NAV);
      o_ynav <= CW'(IY_NAV);
      o_xpal <= CW'(IX_PAL);
      o_ypal <= CW'(IY_PAL);
      o_xdirpal <= 1'b0;
      o_ydirpal <= 1'b0;
      o_hp <= HP_INIT;
      o_alive <= ALIVE_INIT;
      o_brick <= BRICK_INIT;
      o_life <= LW'(VITE);
      d_xnav <= CW'(IX_NAV);
      d_xpal <= CW'(IX_PAL);
      d_ypal <= CW'(IY_PAL);
      d_hp <= HP_INIT;
    end else begin
      state <= state_n;
      o_xnav <= xnav_n;
      o_ynav <= ynav_n;
      o_xpal <= xpal_n;
      o_ypal <= ypal_n;
      o_xdirpal <= xdir_n;
      o_ydirpal <= ydir_n;
      o_hp <= hp_n;
      o_alive <= alive_n;
      o_brick <= brick_n;
      o_life <= life_n;
      if (vsync) begin
        d_xnav <= o_xnav;
        d_xpal <= o_xpal;
        d_ypal <= o_ypal;
        d_hp <= o_hp;
      end
    end
  end
endmodule
